// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: state encoding, opcodes, IR field positions and opcode classification for ctrl_seq
package ctrl_seq_pkg;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;
  typedef enum logic [3:0] {
    IDLE = S_IDLE, T0 = S_T0, T1 = S_T1, T2 = S_T2, T3 = S_T3,
    T4 = S_T4, T5 = S_T5, T6 = S_T6, HALT = S_HALT
  } state_t;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  function automatic logic is_binary(input logic [4:0] op);
    return op >= OP_ADD && op <= OP_ROL;
  endfunction
  function automatic logic is_unary(input logic [4:0] op);
    return op == OP_NEG || op == OP_NOT;
  endfunction
  function automatic logic is_muldiv(input logic [4:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
  function automatic logic is_legal(input logic [4:0] op);
    return is_binary(op) || is_unary(op) || is_muldiv(op) || op == OP_NOP || op == OP_HALT;
  endfunction
endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: strobe/IR bundle between the control sequencer (master) and the bus datapath (slave)
interface ctrl_seq_if #(parameter int NUM_REGS = 16, parameter int OP_W = 5);
  logic [31:0] IR;
  logic mem_ready;
  logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, Zin;
  logic Zlowout, Zhighout, HIin, LOin;
  logic [NUM_REGS-1:0] Rin, Rout;
  logic [OP_W-1:0] alu_op;
  logic run, illegal;
  modport master (
    input  IR, mem_ready,
    output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, Zin,
           Zlowout, Zhighout, HIin, LOin, Rin, Rout, alu_op, run, illegal
  );
  modport slave (
    output IR, mem_ready,
    input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, Zin,
           Zlowout, Zhighout, HIin, LOin, Rin, Rout, alu_op, run, illegal
  );
endinterface

// File: rtl/ctrl_seq_reg_sel_dec.sv
// reg_sel_dec: 4-bit register field to one-hot select; R0 is hardwired zero so bit 0 never asserts
module reg_sel_dec #(parameter int NUM_REGS = 16) (
  input  logic [3:0]          sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);
  always_comb onehot = (en && sel != 4'd0) ? NUM_REGS'(1) << sel : '0;
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: hardwired Moore control unit sequencing fetch/execute of register-format ALU instructions.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with illegal=1 (otherwise they run as nop).
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input logic        Clock,
  input logic        clear,
  ctrl_seq_if.master bus
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  state_t state, state_n;
  logic ill_q, trap_hit, rin_en, rout_en, zin, unused_ir;
  logic [4:0] op;
  logic [3:0] ra, rb, rc, rout_sel;
  assign op        = bus.IR[OP_HI:OP_LO];
  assign ra        = bus.IR[RA_HI:RA_LO];
  assign rb        = bus.IR[RB_HI:RB_LO];
  assign rc        = bus.IR[RC_HI:RC_LO];
  assign unused_ir = ^bus.IR[RC_LO-1:0];
  assign trap_hit  = TRAP && state == T3 && !is_legal(op);
  always_ff @(posedge Clock or posedge clear)
    if (clear) begin
      state <= IDLE;
      ill_q <= 1'b0;
    end else begin
      state <= state_n;
      ill_q <= ill_q | trap_hit;
    end
  always_comb begin
    state_n      = state;
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.run      = state != HALT;
    zin          = 1'b0;
    rin_en       = 1'b0;
    rout_en      = 1'b0;
    rout_sel     = rb;
    case (state)
      IDLE: state_n = T0;
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        state_n   = T1;
      end
      T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        state_n   = bus.mem_ready ? T2 : T1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_n    = T3;
      end
      T3: begin
        // mul/div stage ra into Y first; binary ops stage rb; unary ops go straight to Z
        rout_en  = is_binary(op) || is_unary(op) || is_muldiv(op);
        rout_sel = is_muldiv(op) ? ra : rb;
        bus.Yin  = is_binary(op) || is_muldiv(op);
        zin      = is_unary(op);
        state_n  = rout_en ? T4 : (op == OP_HALT || trap_hit) ? HALT : T0;
      end
      T4: begin
        rout_en     = !is_unary(op);
        rout_sel    = is_muldiv(op) ? rb : rc;
        zin         = !is_unary(op);
        bus.Zlowout = is_unary(op);
        rin_en      = is_unary(op);
        state_n     = is_unary(op) ? T0 : T5;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        bus.LOin    = is_muldiv(op);
        rin_en      = !is_muldiv(op);
        state_n     = is_muldiv(op) ? T6 : T0;
      end
      T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        state_n      = T0;
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end
  assign bus.Zin     = zin;
  assign bus.alu_op  = zin ? OP_W'(op) : '0;
  assign bus.illegal = ill_q;
  reg_sel_dec #(.NUM_REGS(NUM_REGS)) u_rin  (.sel(ra),       .en(rin_en),  .onehot(bus.Rin));
  reg_sel_dec #(.NUM_REGS(NUM_REGS)) u_rout (.sel(rout_sel), .en(rout_en), .onehot(bus.Rout));
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: randomized scoreboard bench; expected strobe vectors per cycle come from an instruction-level model
module tb_ctrl_seq;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [12:0] PCOUT = 13'h1000, MARIN = 13'h0800, INCPC = 13'h0400, READ = 13'h0200;
  localparam logic [12:0] MDRIN = 13'h0100, MDROUT = 13'h0080, IRIN = 13'h0040, YIN = 13'h0020;
  localparam logic [12:0] ZIN = 13'h0010, ZLO = 13'h0008, ZHI = 13'h0004, HIIN = 13'h0002, LOIN = 13'h0001;
  typedef struct packed {
    logic [12:0] s;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
  } obs_t;
  logic Clock = 1'b0;
  logic clear = 1'b1;
  obs_t exp_q[$];
  string tag_q[$];
  obs_t plan[$];
  string plan_tag[$];
  bit plan_mr[$];
  int checks = 0;
  int failures = 0;
  ctrl_seq_if #(.NUM_REGS(16), .OP_W(5)) bus();
  ctrl_seq #(.NUM_REGS(16), .OP_W(5)) dut (.Clock(Clock), .clear(clear), .bus(bus));
  always #5 Clock = ~Clock;
  function automatic logic [15:0] oh(input logic [3:0] r);
    return r == 4'd0 ? 16'h0 : 16'h1 << r;
  endfunction
  function automatic obs_t v(input logic [12:0] s, input logic [3:0] wr = 4'd0, input logic [3:0] rd = 4'd0,
                             input logic [4:0] alu = 5'd0, input logic run = 1'b1, input logic ill = 1'b0);
    obs_t o;
    o.s = s; o.rin = oh(wr); o.rout = oh(rd); o.alu = alu; o.run = run; o.ill = ill;
    return o;
  endfunction
  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'($urandom)};
  endfunction
  task automatic add(input obs_t e, input string t, input bit mr);
    plan.push_back(e); plan_tag.push_back(t); plan_mr.push_back(mr);
  endtask
  // instruction-level model: the full per-cycle strobe trace of one instruction
  task automatic build(input logic [31:0] ir, input int waits, output bit halts);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    plan.delete(); plan_tag.delete(); plan_mr.delete();
    halts = 1'b0;
    add(v(PCOUT | MARIN | INCPC), "T0", 1'($urandom));
    for (int k = 0; k <= waits; k++) add(v(READ | MDRIN), "T1", k == waits);
    add(v(MDROUT | IRIN), "T2", 1'($urandom));
    if (op >= 5'd3 && op <= 5'd10) begin
      add(v(YIN, 0, rb), "T3_bin", 1'($urandom));
      add(v(ZIN, 0, rc, op), "T4_bin", 1'($urandom));
      add(v(ZLO, ra), "T5_bin", 1'($urandom));
    end else if (op == 5'd16 || op == 5'd17) begin
      add(v(ZIN, 0, rb, op), "T3_un", 1'($urandom));
      add(v(ZLO, ra), "T4_un", 1'($urandom));
    end else if (op == 5'd14 || op == 5'd15) begin
      add(v(YIN, 0, ra), "T3_md", 1'($urandom));
      add(v(ZIN, 0, rb, op), "T4_md", 1'($urandom));
      add(v(ZLO | LOIN), "T5_md", 1'($urandom));
      add(v(ZHI | HIIN), "T6_md", 1'($urandom));
    end else begin
      add(v(0), "T3_none", 1'($urandom));
      halts = op == 5'd25 || (TRAP && op != 5'd24);
    end
  endtask
  task automatic cycle(input obs_t e, input string t, input bit mr, input logic [31:0] ir);
    @(posedge Clock);
    #1;
    bus.mem_ready = mr;
    bus.IR = ir;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask
  task automatic do_clear(input logic [31:0] ir);
    @(posedge Clock);
    #1;
    clear = 1'b1;
    exp_q.push_back(v(0)); tag_q.push_back("clear_async");
    cycle(v(0), "clear_release", 1'($urandom), ir);
    clear = 1'b0;
  endtask
  task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_at);
    bit halts, aborted;
    build(ir, waits, halts);
    aborted = 1'b0;
    for (int i = 0; i < plan.size() && !aborted; i++)
      if (i == abort_at) begin
        do_clear(ir);
        aborted = 1'b1;
      end else cycle(plan[i], plan_tag[i], plan_mr[i], ir);
    if (halts && !aborted) begin
      repeat (10) cycle(v(0, 0, 0, 0, 1'b0, TRAP && ir[31:27] != 5'd25), "HALT", 1'($urandom), ir);
      do_clear(ir);
    end
  endtask
  always @(negedge Clock) begin : monitor
    obs_t e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {bus.PCout, bus.MARin, bus.IncPC, bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin,
           bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin, bus.Rin, bus.Rout, bus.alu_op, bus.run, bus.illegal};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got strobes=%h rin=%h rout=%h alu=%b run=%b ill=%b, expected strobes=%h rin=%h rout=%h alu=%b run=%b ill=%b",
                 t, a.s, a.rin, a.rout, a.alu, a.run, a.ill, e.s, e.rin, e.rout, e.alu, e.run, e.ill);
      end
    end
  end
  initial begin
    logic [4:0] op;
    bus.IR = 32'h0;
    bus.mem_ready = 1'b0;
    repeat (3) begin
      @(posedge Clock);
      #1;
      exp_q.push_back(v(0)); tag_q.push_back("reset_idle");
    end
    cycle(v(0), "reset_release", 1'b0, 32'h0);
    clear = 1'b0;
    run_instr(32'h28918000, 0, -1);
    run_instr(32'h28918000, 3, -1);
    run_instr(32'h72280000, 0, -1);
    run_instr(mk(5'd3, 4'd0, 4'd2, 4'd3), 1, -1);
    run_instr(mk(5'd16, 4'd5, 4'd6, 4'd0), 0, -1);
    run_instr(mk(5'd17, 4'd7, 4'd0, 4'd9), 2, -1);
    run_instr(mk(5'd15, 4'd0, 4'd8, 4'd1), 0, -1);
    run_instr(mk(5'd24, 4'd1, 4'd2, 4'd3), 0, -1);
    run_instr(mk(5'd3, 4'd1, 4'd2, 4'd3), 0, 4);
    run_instr(32'hC8000000, 0, -1);
    run_instr(mk(5'd31, 4'd1, 4'd2, 4'd3), 0, -1);
    run_instr(32'h28918000, 0, -1);
    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom);
      if ($urandom_range(0, 2) != 0)
        while (!(op inside {[5'd3:5'd10], 5'd14, 5'd15, 5'd16, 5'd17, 5'd24})) op = 5'($urandom);
      run_instr(mk(op, 4'($urandom), 4'($urandom), 4'($urandom)), $urandom_range(0, 3),
                $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 6)) : -1);
    end
    repeat (3) @(posedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked cycles, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
